trng_postproc: RTL

Post-processing stage between the ring-oscillator entropy source and the TRNG peripheral's register interface. Takes one raw bit per strobe and runs continuous health tests on the raw stream: a repetition count test and an adaptive proportion test. Removes bias with a von Neumann corrector, packs corrected bits into bytes and presents them through a one-byte holding register with a valid/pop handshake. A health failure is sticky and blocks all output until software clears it.

---
 rtl/trng_postproc_pkg.sv | 15 +
 rtl/trng_postproc_if.sv | 21 ++
 rtl/trng_postproc_health.sv | 81 ++++++++
 rtl/trng_postproc.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/trng_postproc_pkg.sv
// Shared state encoding and default health-test thresholds for the TRNG post-processor.
package trng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_FAIL   = 2'd3
  } state_e;

  localparam int RCT_CUTOFF = 16;
  localparam int APT_WINDOW = 64;
  localparam int APT_CUTOFF = 48;

endpackage

// File: rtl/trng_postproc_if.sv
// Entropy-in / byte-out handshake bundle between the TRNG register block and the post-processor.
interface trng_postproc_if;
  logic       en;
  logic       raw_bit;
  logic       raw_valid;
  logic       rd_pop;
  logic       fail_clr;
  logic [7:0] data_out;
  logic       data_valid;
  logic       health_fail;

  modport master (
    output en, raw_bit, raw_valid, rd_pop, fail_clr,
    input  data_out, data_valid, health_fail
  );

  modport slave (
    input  en, raw_bit, raw_valid, rd_pop, fail_clr,
    output data_out, data_valid, health_fail
  );
endinterface

// File: rtl/trng_postproc_health.sv
// Continuous repetition-count and adaptive-proportion tests on the raw bit stream.
// fail is combinational on the failing sample so the owner can register it on that edge.
module trng_health
  import trng_pkg::*;
#(
  parameter int RCT_CUTOFF = trng_pkg::RCT_CUTOFF,
  parameter int APT_WINDOW = trng_pkg::APT_WINDOW,
  parameter int APT_CUTOFF = trng_pkg::APT_CUTOFF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic sample,
  input  logic valid,
  output logic fail
);

  localparam int RCT_W = $clog2(RCT_CUTOFF + 1);
  localparam int IDX_W = $clog2(APT_WINDOW);
  localparam int APT_W = $clog2(APT_CUTOFF + 1);

  logic [RCT_W-1:0] rct_cnt_q, rct_cnt_d;
  logic             prev_q, prev_d;
  logic             seen_q, seen_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ref_q, ref_d;
  logic [APT_W-1:0] match_q, match_d;

  always_comb begin
    rct_cnt_d = rct_cnt_q;
    prev_d    = prev_q;
    seen_d    = seen_q;
    idx_d     = idx_q;
    ref_d     = ref_q;
    match_d   = match_q;
    fail      = 1'b0;
    if (clear) begin
      rct_cnt_d = '0;
      prev_d    = 1'b0;
      seen_d    = 1'b0;
      idx_d     = '0;
      ref_d     = 1'b0;
      match_d   = '0;
    end else if (valid) begin
      seen_d = 1'b1;
      prev_d = sample;
      // seen_q gates the compare so the first sample after a clear starts a fresh run
      if (seen_q && (sample == prev_q)) rct_cnt_d = rct_cnt_q + 1'b1;
      else                              rct_cnt_d = RCT_W'(1);

      if (idx_q == '0) begin
        ref_d   = sample;
        match_d = APT_W'(1);
      end else if (sample == ref_q) begin
        match_d = match_q + 1'b1;
      end
      idx_d = (idx_q == IDX_W'(APT_WINDOW - 1)) ? '0 : idx_q + 1'b1;

      fail = (rct_cnt_d == RCT_W'(RCT_CUTOFF)) || (match_d == APT_W'(APT_CUTOFF));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rct_cnt_q <= '0;
      prev_q    <= 1'b0;
      seen_q    <= 1'b0;
      idx_q     <= '0;
      ref_q     <= 1'b0;
      match_q   <= '0;
    end else begin
      rct_cnt_q <= rct_cnt_d;
      prev_q    <= prev_d;
      seen_q    <= seen_d;
      idx_q     <= idx_d;
      ref_q     <= ref_d;
      match_q   <= match_d;
    end
  end

endmodule

// File: rtl/trng_postproc.sv
// Health-gated von Neumann debiaser with LSB-first byte assembly and a one-byte pop register.
// Any health failure parks the block in FAIL with all output suppressed until fail_clr.
module trng_postproc
  import trng_pkg::*;
#(
  parameter int RCT_CUTOFF = trng_pkg::RCT_CUTOFF,
  parameter int APT_WINDOW = trng_pkg::APT_WINDOW,
  parameter int APT_CUTOFF = trng_pkg::APT_CUTOFF
) (
  input logic           clk,
  input logic           rst,
  trng_postproc_if.slave io
);

  localparam int WARM_W = $clog2(APT_WINDOW);

  state_e            state_q, state_d;
  logic [WARM_W-1:0] warm_q, warm_d;
  logic              ph_q, ph_d;
  logic              b0_q, b0_d;
  logic [7:0]        asm_q, asm_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [7:0]        hold_q, hold_d;
  logic              hvld_q, hvld_d;

  logic       h_clear, h_fail, active, pop;
  logic [7:0] asm_nxt;

  assign h_clear = (state_q == ST_IDLE) || (state_q == ST_FAIL);

  trng_health #(
    .RCT_CUTOFF (RCT_CUTOFF),
    .APT_WINDOW (APT_WINDOW),
    .APT_CUTOFF (APT_CUTOFF)
  ) u_health (
    .clk    (clk),
    .rst    (rst),
    .clear  (h_clear),
    .sample (io.raw_bit),
    .valid  (io.raw_valid),
    .fail   (h_fail)
  );

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    unique case (state_q)
      ST_IDLE: begin
        warm_d = '0;
        if (io.en) state_d = ST_WARMUP;
      end
      ST_WARMUP: begin
        if (h_fail)      state_d = ST_FAIL;
        else if (!io.en) state_d = ST_IDLE;
        else if (io.raw_valid) begin
          if (warm_q == WARM_W'(APT_WINDOW - 1)) begin
            state_d = ST_RUN;
            warm_d  = '0;
          end else begin
            warm_d = warm_q + 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (h_fail)      state_d = ST_FAIL;
        else if (!io.en) state_d = ST_IDLE;
      end
      ST_FAIL: begin
        warm_d = '0;
        if (io.fail_clr) state_d = io.en ? ST_WARMUP : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath only advances while RUN persists across the edge; any exit (fail, disable)
  // or the entry edge itself wipes corrector, assembly and holding state.
  assign active = (state_q == ST_RUN) && (state_d == ST_RUN);
  assign pop    = io.rd_pop && hvld_q;

  always_comb begin
    ph_d    = ph_q;
    b0_d    = b0_q;
    asm_d   = asm_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    hvld_d  = hvld_q;
    asm_nxt = asm_q;
    if (!active) begin
      ph_d   = 1'b0;
      b0_d   = 1'b0;
      asm_d  = '0;
      cnt_d  = '0;
      hold_d = '0;
      hvld_d = 1'b0;
    end else begin
      if (pop) begin
        hold_d = '0;
        hvld_d = 1'b0;
      end
      if (io.raw_valid) begin
        if (!ph_q) begin
          ph_d = 1'b1;
          b0_d = io.raw_bit;
        end else begin
          ph_d = 1'b0;
          // 10 -> 1, 01 -> 0: the emitted bit is the first bit of an unequal pair
          if (b0_q != io.raw_bit) begin
            asm_nxt[cnt_q] = b0_q;
            if (cnt_q == 3'd7) begin
              cnt_d = '0;
              asm_d = '0;
              if (!hvld_q || pop) begin
                hold_d = asm_nxt;
                hvld_d = 1'b1;
              end
            end else begin
              asm_d = asm_nxt;
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      warm_q  <= '0;
      ph_q    <= 1'b0;
      b0_q    <= 1'b0;
      asm_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      hvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      ph_q    <= ph_d;
      b0_q    <= b0_d;
      asm_q   <= asm_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      hvld_q  <= hvld_d;
    end
  end

  assign io.data_out    = hold_q;
  assign io.data_valid  = hvld_q;
  assign io.health_fail = (state_q == ST_FAIL);

endmodule
